// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops plus iterative unsigned
// multiply/divide, with a one-deep registered result and flag set.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero_F,
    output logic             Sign_F,
    output logic             Carry_F,
    output logic             Ovf_F,
    output logic             Err_F
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SRA   = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_SLT   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   result_q, res_d;
    logic               zero_q, sign_q, carry_q, ovf_q, err_q;
    logic               carry_d, ovf_d, err_d;
    logic               res_load, load_ops, accept;

    // Iterative datapath: hi holds partial product / remainder, lo holds multiplier / quotient.
    logic [WIDTH-1:0]   hi_q, lo_q, b_q, hi_n, lo_n;
    logic               div_q, hisel_q;

    logic [WIDTH-1:0]   sc_res;
    logic               sc_c, sc_v, sc_err, is_multi, start_multi;
    logic [WIDTH:0]     sum_ext;
    logic signed [WIDTH-1:0] a_s, b_s, sra_s;
    logic [SHW-1:0]     shamt;

    function automatic logic is_zero(input logic [WIDTH-1:0] r);
        return (r == '0);
    endfunction

    assign a_s   = inA;
    assign b_s   = inB;
    assign shamt = inB[SHW-1:0];
    assign sra_s = a_s >>> shamt;
    assign sum_ext = {1'b0, inA} + {1'b0, inB};
    assign is_multi = ALU_control inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
    assign start_multi = is_multi && (inB != '0);

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_err = 1'b0;
        case (ALU_control)
            OP_ADD: begin
                sc_res = sum_ext[WIDTH-1:0];
                sc_c   = sum_ext[WIDTH];
                sc_v   = (inA[WIDTH-1] == inB[WIDTH-1]) && (sc_res[WIDTH-1] != inA[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = inA - inB;
                sc_c   = (inA < inB);
                sc_v   = (inA[WIDTH-1] != inB[WIDTH-1]) && (sc_res[WIDTH-1] != inA[WIDTH-1]);
            end
            OP_AND:   sc_res = inA & inB;
            OP_OR:    sc_res = inA | inB;
            OP_XOR:   sc_res = inA ^ inB;
            OP_SLTU:  sc_res = {{(WIDTH-1){1'b0}}, (inA < inB)};
            OP_SLT:   sc_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLL:   sc_res = inA << shamt;
            OP_SRL:   sc_res = inA >> shamt;
            OP_SRA:   sc_res = sra_s;
            // Only reached with B==0: multiplies are trivially zero, divides take RISC-V style defaults.
            OP_MUL, OP_MULHU: sc_res = '0;
            OP_DIVU:  sc_res = '1;
            OP_REMU:  sc_res = inA;
            default:  sc_err = 1'b1;
        endcase
    end

    logic [WIDTH:0] madd, dsh, ddiff;
    always_comb begin
        madd  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        dsh   = {hi_q, lo_q[WIDTH-1]};
        ddiff = dsh - {1'b0, b_q};
        if (!div_q) begin
            hi_n = madd[WIDTH:1];
            lo_n = {madd[0], lo_q[WIDTH-1:1]};
        end else if (!ddiff[WIDTH]) begin
            hi_n = ddiff[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            hi_n = dsh[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        res_load = 1'b0;
        load_ops = 1'b0;
        res_d    = sc_res;
        carry_d  = sc_c;
        ovf_d    = sc_v;
        err_d    = sc_err;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (start_multi) begin
                        state_d  = BUSY;
                        count_d  = CW'(WIDTH);
                        load_ops = 1'b1;
                    end else begin
                        state_d  = DONE;
                        res_load = 1'b1;
                    end
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                count_d = count_q - 1'b1;
                // The last step's outcome is registered directly, so DONE follows the final step.
                if (count_q == CW'(1)) begin
                    state_d  = DONE;
                    res_load = 1'b1;
                    res_d    = hisel_q ? hi_n : lo_n;
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            sign_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (res_load) begin
                result_q <= res_d;
                zero_q   <= is_zero(res_d);
                sign_q   <= res_d[WIDTH-1];
                carry_q  <= carry_d;
                ovf_q    <= ovf_d;
                err_q    <= err_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_ops) begin
            hi_q    <= '0;
            lo_q    <= inA;
            b_q     <= inB;
            div_q   <= ALU_control[2];
            hisel_q <= ALU_control[0];
        end else if (state_q == BUSY) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
        end
    end

    assign out_valid = (state_q == DONE);
    assign Result    = result_q;
    assign Zero_F    = zero_q;
    assign Sign_F    = sign_q;
    assign Carry_F   = carry_q;
    assign Ovf_F     = ovf_q;
    assign Err_F     = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32.
module tb_alu_seq;
    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] inA, inB, Result;
    logic [3:0]  ALU_control;
    logic        Zero_F, Sign_F, Carry_F, Ovf_F, Err_F;
    int          tests, fails;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inA(inA), .inB(inB), .ALU_control(ALU_control),
        .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
        .Zero_F(Zero_F), .Sign_F(Sign_F), .Carry_F(Carry_F), .Ovf_F(Ovf_F), .Err_F(Err_F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        ALU_control = op; inA = a; inB = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Latency counted from the cycle the op is presented (single-cycle op = 1).
    task automatic wait_result(output int lat, output bit busy_ok);
        lat = 1; busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; out_ready = 1'b1;
        ALU_control = 4'b0000; inA = 32'd1; inB = 32'd1; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        tests++; if (Result !== 32'h0) begin fails++; $display("FAIL rst_result: got %h want 0", Result); end
        tests++; if ({Zero_F, Sign_F, Carry_F, Ovf_F, Err_F} !== 5'b0)
            begin fails++; $display("FAIL rst_flags: got %b want 00000", {Zero_F, Sign_F, Carry_F, Ovf_F, Err_F}); end
        in_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_noaccept: got %b want 0", out_valid); end
    endtask

    task automatic test_addsub;
        out_ready = 1'b1;
        drive(4'b0000, 32'h7FFF_FFFF, 32'h1);
        tests++; if (out_valid !== 1'b1 || Result !== 32'h8000_0000)
            begin fails++; $display("FAIL add_ovf_res: got v=%b %h want v=1 80000000", out_valid, Result); end
        tests++; if ({Zero_F, Sign_F, Carry_F, Ovf_F, Err_F} !== 5'b01010)
            begin fails++; $display("FAIL add_ovf_flags: got %b want 01010", {Zero_F, Sign_F, Carry_F, Ovf_F, Err_F}); end
        drive(4'b0000, 32'hFFFF_FFFF, 32'h2);
        tests++; if (Result !== 32'h1 || Carry_F !== 1'b1 || Ovf_F !== 1'b0)
            begin fails++; $display("FAIL add_carry: got %h c=%b v=%b want 00000001 c=1 v=0", Result, Carry_F, Ovf_F); end
        drive(4'b0001, 32'd5, 32'd5);
        tests++; if (Result !== 32'h0 || Zero_F !== 1'b1 || Carry_F !== 1'b0)
            begin fails++; $display("FAIL sub_zero: got %h z=%b c=%b want 0 z=1 c=0", Result, Zero_F, Carry_F); end
        drive(4'b0001, 32'd3, 32'd5);
        tests++; if (Result !== 32'hFFFF_FFFE || Carry_F !== 1'b1 || Sign_F !== 1'b1 || Ovf_F !== 1'b0)
            begin fails++; $display("FAIL sub_borrow: got %h c=%b s=%b v=%b want fffffffe c=1 s=1 v=0", Result, Carry_F, Sign_F, Ovf_F); end
        drive(4'b0001, 32'h8000_0000, 32'h1);
        tests++; if (Result !== 32'h7FFF_FFFF || Ovf_F !== 1'b1)
            begin fails++; $display("FAIL sub_ovf: got %h v=%b want 7fffffff v=1", Result, Ovf_F); end
    endtask

    task automatic test_shift_cmp;
        drive(4'b0110, 32'h8000_0000, 32'hFFFF_FFFF);
        tests++; if (Result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sra: got %h want ffffffff", Result); end
        drive(4'b0101, 32'h8000_0000, 32'hFFFF_FFFF);
        tests++; if (Result !== 32'h1) begin fails++; $display("FAIL srl: got %h want 00000001", Result); end
        drive(4'b1001, 32'hFFFF_FFFF, 32'h1);
        tests++; if (Result !== 32'h1) begin fails++; $display("FAIL slt: got %h want 00000001", Result); end
        drive(4'b1000, 32'hFFFF_FFFF, 32'h1);
        tests++; if (Result !== 32'h0 || Zero_F !== 1'b1) begin fails++; $display("FAIL sltu: got %h z=%b want 0 z=1", Result, Zero_F); end
        drive(4'b1111, 32'h1234, 32'h5678);
        tests++; if (Result !== 32'h0 || Err_F !== 1'b1 || Carry_F !== 1'b0)
            begin fails++; $display("FAIL illegal: got %h e=%b c=%b want 0 e=1 c=0", Result, Err_F, Carry_F); end
    endtask

    task automatic test_muldiv;
        int lat; bit busy_ok;
        drive(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result(lat, busy_ok);
        tests++; if (lat != 33) begin fails++; $display("FAIL mulhu_latency: got %0d want 33", lat); end
        tests++; if (!busy_ok) begin fails++; $display("FAIL mulhu_busy_ready: got in_ready high want low"); end
        tests++; if (Result !== 32'hFFFF_FFFE || Carry_F !== 1'b0 || Sign_F !== 1'b1)
            begin fails++; $display("FAIL mulhu: got %h c=%b s=%b want fffffffe c=0 s=1", Result, Carry_F, Sign_F); end
        drive(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result(lat, busy_ok);
        tests++; if (Result !== 32'h1 || lat != 33) begin fails++; $display("FAIL mul: got %h lat=%0d want 00000001 lat=33", Result, lat); end
        drive(4'b1100, 32'd100, 32'd7);
        wait_result(lat, busy_ok);
        tests++; if (Result !== 32'd14) begin fails++; $display("FAIL divu: got %0d want 14", Result); end
        drive(4'b1101, 32'd100, 32'd7);
        wait_result(lat, busy_ok);
        tests++; if (Result !== 32'd2) begin fails++; $display("FAIL remu: got %0d want 2", Result); end
        drive(4'b1100, 32'd9, 32'd0);
        tests++; if (out_valid !== 1'b1 || Result !== 32'hFFFF_FFFF || Err_F !== 1'b0)
            begin fails++; $display("FAIL divu_zero: got v=%b %h e=%b want v=1 ffffffff e=0", out_valid, Result, Err_F); end
        drive(4'b1101, 32'd9, 32'd0);
        tests++; if (out_valid !== 1'b1 || Result !== 32'd9) begin fails++; $display("FAIL remu_zero: got v=%b %0d want v=1 9", out_valid, Result); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        in_valid = 1'b1; ALU_control = 4'b0010; inA = 32'hFF00_FF00; inB = 32'h0F0F_0F0F;
        @(posedge clk); #1;
        tests++; if (Result !== 32'h0F00_0F00) begin fails++; $display("FAIL b2b_and: got %h want 0f000f00", Result); end
        ALU_control = 4'b0100; inA = 32'h1234_0000; inB = 32'h0000_5678;
        @(posedge clk); #1;
        tests++; if (Result !== 32'h1234_5678) begin fails++; $display("FAIL b2b_or: got %h want 12345678", Result); end
        ALU_control = 4'b0011; inA = 32'h1; inB = 32'h4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++; if (Result !== 32'h10 || out_valid !== 1'b1) begin fails++; $display("FAIL b2b_sll: got %h v=%b want 00000010 v=1", Result, out_valid); end
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_retire: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        bit hold_ok;
        out_ready = 1'b0;
        drive(4'b0000, 32'd2, 32'd3);
        ALU_control = 4'b0111; inA = 32'hF0F0_0000; inB = 32'h0FF0_00FF; in_valid = 1'b1;
        hold_ok = 1'b1;
        repeat (5) begin
            if (Result !== 32'd5 || out_valid !== 1'b1 || in_ready !== 1'b0) hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        tests++; if (!hold_ok || Result !== 32'd5)
            begin fails++; $display("FAIL bp_hold: got %h rdy=%b want 00000005 rdy=0 throughout", Result, in_ready); end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || Result !== 32'hFF00_00FF || Sign_F !== 1'b1)
            begin fails++; $display("FAIL bp_xor: got v=%b %h s=%b want v=1 ff0000ff s=1", out_valid, Result, Sign_F); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop;
        bit never;
        out_ready = 1'b1;
        drive(4'b1100, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
            begin fails++; $display("FAIL midop_busy: got v=%b rdy=%b want v=0 rdy=0", out_valid, in_ready); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || Result !== 32'h0)
            begin fails++; $display("FAIL midop_reset: got rdy=%b v=%b %h want rdy=1 v=0 0", in_ready, out_valid, Result); end
        never = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) never = 1'b0;
        end
        tests++; if (!never) begin fails++; $display("FAIL midop_discard: got out_valid high want never"); end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        inA = '0; inB = '0; ALU_control = '0;
        test_reset();
        test_addsub();
        test_shift_cmp();
        test_muldiv();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
